// File: rtl/register_file.sv
// register_file
//   32-entry general-purpose register bank for a single-cycle MIPS datapath.
//   Writes are clocked. The two read ports are combinational.
//   Register 0 always reads as zero.
//   Register 29 ($sp) loads SP_RESET_VALUE on reset.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous reset, active-high
//   RegWrite       write enable from the control unit
//   WriteRegister  destination index (rt or rd, selected by the RegDst mux)
//   WriteData      write value (selected by the MemtoReg mux)
//   ReadRegister1  rs index
//   ReadRegister2  rt index
//   ReadData1      contents of ReadRegister1
//   ReadData2      contents of ReadRegister2
//
// Configuration
//   REGFILE_BYPASS_EN  When defined, enables write-through forwarding. A read of
//                      the register being written returns WriteData in the same
//                      cycle. When undefined, a same-cycle read returns the stored
//                      (old) value.

module register_file #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET_VALUE = 32'h0000_03FC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int SP_INDEX = 29;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Index 0 is never written, so its storage keeps the zero loaded by reset.
  assign wr_en = RegWrite && (WriteRegister != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  // Reset takes priority over any write that is presented at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET_VALUE : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass1;
  logic bypass2;

  // Forwarding is qualified with !reset because a write presented during reset
  // is discarded and must not be seen on the read ports.
  // wr_en already excludes index 0, so the zero register is never bypassed.
  assign bypass1 = wr_en && !reset && (WriteRegister == ReadRegister1);
  assign bypass2 = wr_en && !reset && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = (ReadRegister1 == '0) ? '0 : regs_q[ReadRegister1];
    ReadData2 = (ReadRegister2 == '0) ? '0 : regs_q[ReadRegister2];
    if (bypass1) ReadData1 = WriteData;
    if (bypass2) ReadData2 = WriteData;
  end
`else
  always_comb begin
    ReadData1 = (ReadRegister1 == '0) ? '0 : regs_q[ReadRegister1];
    ReadData2 = (ReadRegister2 == '0) ? '0 : regs_q[ReadRegister2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam logic [31:0] SP_RST = 32'h0000_03FC;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: architectural register contents after the most recent edge.
  logic [31:0] model [32];
  bit          model_valid = 1'b0;
  logic [31:0] last_rd1;
  logic [31:0] last_rd2;

  function automatic logic [31:0] expected_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !reset && WriteRegister != 5'd0 && WriteRegister == idx)
      return WriteData;
`endif
    return model[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check both ports before the edge, then advance the model.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    #1;
    last_rd1 = ReadData1;
    last_rd2 = ReadData2;
    if (model_valid) begin
      check("port1", ReadData1, expected_read(ra1));
      check("port2", ReadData2, expected_read(ra2));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP_RST : 32'h0;
      model_valid = 1'b1;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    logic [31:0] old27;
    logic [31:0] v21;
    logic [4:0]  wa;
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    // Reset values
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
    check("rst_r0", last_rd1, 32'h0);
    check("rst_r8", last_rd2, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd29);
    check("rst_sp", last_rd1, SP_RST);

    // Write then read back; a neighbour is undisturbed
    step(1'b0, 1'b1, 5'd21, 32'hDEAD_BEEF, 5'd8, 5'd29);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd8);
    check("wr_r21", last_rd1, 32'hDEAD_BEEF);
    check("wr_r8", last_rd2, 32'h0);

    // Writes to $zero are ignored
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("zero_same", last_rd1, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("zero_after", last_rd1, 32'h0);

    // Reset dominates a simultaneous write
    step(1'b0, 1'b1, 5'd27, 32'h0BAD_F00D, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd27, 32'h1234_5678, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd27, 5'd21);
    check("rstprio_r27", last_rd1, 32'h0);
    check("rstprio_r21", last_rd2, 32'h0);

    // Same-cycle read of the write target
    step(1'b0, 1'b1, 5'd27, 32'h1111_2222, 5'd0, 5'd0);
    old27 = 32'h1111_2222;
    step(1'b0, 1'b1, 5'd27, 32'hA5A5_A5A5, 5'd27, 5'd27);
`ifdef REGFILE_BYPASS_EN
    check("samecyc_r27", last_rd2, 32'hA5A5_A5A5);
`else
    check("samecyc_r27", last_rd2, old27);
`endif
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd27);
    check("after_r27", last_rd2, 32'hA5A5_A5A5);

    // Dual port on the same index; then four idle edges change nothing
    step(1'b0, 1'b1, 5'd21, 32'hCAFE_0021, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd21);
    check("dual_p1", last_rd1, 32'hCAFE_0021);
    check("dual_p2", last_rd2, 32'hCAFE_0021);
    v21 = last_rd1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 5'd21, 32'hFFFF_0000, 5'd21, 5'd27);
    check("idle_r21", last_rd1, v21);
    check("idle_r27", last_rd2, 32'hA5A5_A5A5);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r1;
      logic [4:0] r2;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), wa, $urandom, r1, r2);
    end

    // Sweep every register once to catch any lingering divergence
    for (int i = 0; i < 32; i += 2) step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
